ac_rle_enc: RTL and testbench

- Parametrised successor to the AC run-length stage. It consumes one quantised block per BLK_LEN coefficients, in zig-zag order, over a valid/ready stream.
- It emits JPEG-ready symbols {run, size, amplitude}, with true deferred ZRL handling, EOB insertion and back-pressure.
- It sits between the zig-zag/quantiser and the Huffman coder. The DC coefficient is passed through with a flag so the DC differencer downstream can pick it off.

---
 rtl/ac_rle_enc_if.sv | 41 ++++
 rtl/ac_rle_enc.sv | 232 +++++++++++++++++++++++
 tb/tb_ac_rle_enc.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ac_rle_enc_if.sv
// ---------------------------------------------------------------------------
// ac_rle_enc_if
// Stream bundle for the AC run-length encoder.
//   Coefficient side : coef_i, coef_valid_i, coef_sop_i  -> encoder
//                      coef_ready_o                      <- encoder
//   Symbol side      : sym_run_o, sym_size_o, sym_amp_o,
//                      sym_dc_o, sym_last_o, sym_valid_o <- encoder
//                      sym_ready_i                       -> encoder
//   Status           : err_sop_o                         <- encoder
// The "slave" modport is the encoder's view; "master" is the surrounding
// logic (quantiser on one side, Huffman coder on the other).
// ---------------------------------------------------------------------------
interface ac_rle_enc_if #(
  parameter int COEF_W = 12,
  parameter int SIZE_W = 4
);
  logic signed [COEF_W-1:0] coef_i;
  logic                     coef_valid_i;
  logic                     coef_sop_i;
  logic                     coef_ready_o;
  logic [3:0]               sym_run_o;
  logic [SIZE_W-1:0]        sym_size_o;
  logic [COEF_W-1:0]        sym_amp_o;
  logic                     sym_dc_o;
  logic                     sym_last_o;
  logic                     sym_valid_o;
  logic                     sym_ready_i;
  logic                     err_sop_o;

  modport slave (
    input  coef_i, coef_valid_i, coef_sop_i, sym_ready_i,
    output coef_ready_o, sym_run_o, sym_size_o, sym_amp_o,
           sym_dc_o, sym_last_o, sym_valid_o, err_sop_o
  );

  modport master (
    output coef_i, coef_valid_i, coef_sop_i, sym_ready_i,
    input  coef_ready_o, sym_run_o, sym_size_o, sym_amp_o,
           sym_dc_o, sym_last_o, sym_valid_o, err_sop_o
  );
endinterface

// File: rtl/ac_rle_enc.sv
// ---------------------------------------------------------------------------
// ac_rle_enc
// Run-length encoder between the zig-zag/quantiser and the Huffman coder.
// Consumes BLK_LEN coefficients per block (index 0 = DC) and produces
// JPEG symbols {run, size, amplitude}. Runs of 16+ zeros before a nonzero
// coefficient are split into ZRL symbols {15,0,0}; trailing zeros become
// a single EOB {0,0,0} when EOB_EN=1, otherwise they are dropped.
// Ports:
//   clk_i  - clock
//   rst_i  - synchronous active-high reset
//   bus    - ac_rle_enc_if.slave (coefficient in, symbol out, err_sop_o)
// The symbol output is a single register stage loaded on the accepting
// edge; coef_ready_o is combinational from state and output occupancy.
// ---------------------------------------------------------------------------
module ac_rle_enc #(
  parameter int COEF_W  = 12,
  parameter int BLK_LEN = 64,
  parameter int SIZE_W  = 4,
  parameter int EOB_EN  = 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  ac_rle_enc_if.slave   bus
);

  localparam int             IDX_W    = (BLK_LEN > 2) ? $clog2(BLK_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLK_LEN - 1);

  typedef enum logic [1:0] {ST_ACCEPT, ST_ZRL, ST_EOB} state_t;

  // Bit-length of |c|; 0 for c == 0.
  function automatic logic [SIZE_W-1:0] f_size(input logic signed [COEF_W-1:0] c);
    logic [COEF_W-1:0] mag;
    logic [SIZE_W-1:0] sz;
    mag = c[COEF_W-1] ? COEF_W'(-c) : COEF_W'(c);
    sz  = '0;
    for (int i = 0; i < COEF_W; i++) begin
      if (mag[i]) sz = SIZE_W'(i + 1);
    end
    return sz;
  endfunction

  // JPEG amplitude bits: c for positive, (c-1) truncated to size bits
  // for negative (the one's complement of |c|).
  function automatic logic [COEF_W-1:0] f_amp(input logic signed [COEF_W-1:0] c,
                                              input logic [SIZE_W-1:0]    sz);
    logic [COEF_W-1:0] mask;
    logic [COEF_W-1:0] cm1;
    mask = (COEF_W'(1) << sz) - COEF_W'(1);
    cm1  = COEF_W'(c) - COEF_W'(1);
    return c[COEF_W-1] ? (cm1 & mask) : COEF_W'(c);
  endfunction

  state_t             r_state;
  logic [IDX_W-1:0]   r_idx;
  logic [5:0]         r_zcnt;
  logic [SIZE_W-1:0]  r_hold_size;
  logic [COEF_W-1:0]  r_hold_amp;
  logic               r_hold_last;
  logic [3:0]         r_run;
  logic [SIZE_W-1:0]  r_size;
  logic [COEF_W-1:0]  r_amp;
  logic               r_dc;
  logic               r_last;
  logic               r_valid;
  logic               r_err;

  state_t             w_state_nxt;
  logic [IDX_W-1:0]   w_idx_nxt;
  logic [5:0]         w_zcnt_nxt;
  logic [SIZE_W-1:0]  w_hold_size_nxt;
  logic [COEF_W-1:0]  w_hold_amp_nxt;
  logic               w_hold_last_nxt;
  logic               w_err_nxt;
  logic               w_emit;
  logic [3:0]         w_e_run;
  logic [SIZE_W-1:0]  w_e_size;
  logic [COEF_W-1:0]  w_e_amp;
  logic               w_e_dc;
  logic               w_e_last;

  logic               w_load_ok;
  logic               w_ready;
  logic               w_acc;
  logic               w_is_last;
  logic               w_zero;
  logic [SIZE_W-1:0]  w_c_size;
  logic [COEF_W-1:0]  w_c_amp;

  // Output register can take a new symbol when empty or draining this cycle.
  assign w_load_ok = !r_valid || bus.sym_ready_i;
  assign w_ready   = (r_state == ST_ACCEPT) && w_load_ok && !rst_i;
  assign w_acc     = bus.coef_valid_i && w_ready;
  assign w_is_last = (r_idx == LAST_IDX);
  assign w_zero    = (bus.coef_i == '0);
  assign w_c_size  = f_size(bus.coef_i);
  assign w_c_amp   = f_amp(bus.coef_i, w_c_size);

  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_zcnt_nxt      = r_zcnt;
    w_hold_size_nxt = r_hold_size;
    w_hold_amp_nxt  = r_hold_amp;
    w_hold_last_nxt = r_hold_last;
    w_err_nxt       = 1'b0;
    w_emit          = 1'b0;
    w_e_run         = '0;
    w_e_size        = '0;
    w_e_amp         = '0;
    w_e_dc          = 1'b0;
    w_e_last        = 1'b0;

    unique case (r_state)
      ST_ACCEPT: begin
        if (w_acc) begin
          if (bus.coef_sop_i) begin
            // A sop always restarts the block; mid-block it also flags an
            // error and the pending zeros of the old block are dropped.
            w_err_nxt  = (r_idx != '0);
            w_emit     = 1'b1;
            w_e_size   = w_c_size;
            w_e_amp    = w_c_amp;
            w_e_dc     = 1'b1;
            w_idx_nxt  = IDX_W'(1);
            w_zcnt_nxt = '0;
          end else if (r_idx != '0) begin
            w_idx_nxt = w_is_last ? '0 : r_idx + IDX_W'(1);
            if (w_zero) begin
              if (w_is_last) begin
                w_zcnt_nxt = '0;
                if (EOB_EN != 0) w_state_nxt = ST_EOB;
              end else begin
                w_zcnt_nxt = r_zcnt + 6'd1;
              end
            end else if (r_zcnt < 6'd16) begin
              w_emit     = 1'b1;
              w_e_run    = r_zcnt[3:0];
              w_e_size   = w_c_size;
              w_e_amp    = w_c_amp;
              w_e_last   = w_is_last;
              w_zcnt_nxt = '0;
            end else begin
              // First ZRL goes out on the accepting edge; the coefficient
              // is parked until the remaining run drops below 16.
              w_emit          = 1'b1;
              w_e_run         = 4'd15;
              w_zcnt_nxt      = r_zcnt - 6'd16;
              w_hold_size_nxt = w_c_size;
              w_hold_amp_nxt  = w_c_amp;
              w_hold_last_nxt = w_is_last;
              w_state_nxt     = ST_ZRL;
            end
          end
          // idx==0 without sop: coefficient is dropped, nothing changes.
        end
      end
      ST_ZRL: begin
        if (w_load_ok) begin
          w_emit = 1'b1;
          if (r_zcnt >= 6'd16) begin
            w_e_run    = 4'd15;
            w_zcnt_nxt = r_zcnt - 6'd16;
          end else begin
            w_e_run     = r_zcnt[3:0];
            w_e_size    = r_hold_size;
            w_e_amp     = r_hold_amp;
            w_e_last    = r_hold_last;
            w_zcnt_nxt  = '0;
            w_state_nxt = ST_ACCEPT;
          end
        end
      end
      ST_EOB: begin
        if (w_load_ok) begin
          w_emit      = 1'b1;
          w_e_last    = 1'b1;
          w_state_nxt = ST_ACCEPT;
        end
      end
      default: w_state_nxt = ST_ACCEPT;
    endcase
  end

  // ---- control and output register stage ----
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_ACCEPT;
      r_idx   <= '0;
      r_zcnt  <= '0;
      r_run   <= '0;
      r_size  <= '0;
      r_amp   <= '0;
      r_dc    <= 1'b0;
      r_last  <= 1'b0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_zcnt  <= w_zcnt_nxt;
      r_err   <= w_err_nxt;
      if (w_emit) begin
        r_run   <= w_e_run;
        r_size  <= w_e_size;
        r_amp   <= w_e_amp;
        r_dc    <= w_e_dc;
        r_last  <= w_e_last;
        r_valid <= 1'b1;
      end else if (w_load_ok) begin
        r_valid <= 1'b0;
      end
    end
  end

  // ---- parked coefficient (data only, qualified by r_state) ----
  always_ff @(posedge clk_i) begin
    r_hold_size <= w_hold_size_nxt;
    r_hold_amp  <= w_hold_amp_nxt;
    r_hold_last <= w_hold_last_nxt;
  end

  assign bus.coef_ready_o = w_ready;
  assign bus.sym_run_o    = r_run;
  assign bus.sym_size_o   = r_size;
  assign bus.sym_amp_o    = r_amp;
  assign bus.sym_dc_o     = r_dc;
  assign bus.sym_last_o   = r_last;
  assign bus.sym_valid_o  = r_valid;
  assign bus.err_sop_o    = r_err;

endmodule

// File: tb/tb_ac_rle_enc.sv
module tb_ac_rle_enc;

  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  ac_rle_enc_if #(.COEF_W(12), .SIZE_W(4)) if0 ();
  ac_rle_enc_if #(.COEF_W(12), .SIZE_W(4)) if1 ();

  ac_rle_enc #(.COEF_W(12), .BLK_LEN(64), .SIZE_W(4), .EOB_EN(1)) u_dut0 (
    .clk_i(clk_i), .rst_i(rst_i), .bus(if0));
  ac_rle_enc #(.COEF_W(12), .BLK_LEN(16), .SIZE_W(4), .EOB_EN(0)) u_dut1 (
    .clk_i(clk_i), .rst_i(rst_i), .bus(if1));

  typedef struct packed {
    logic [3:0]  run;
    logic [3:0]  size;
    logic [11:0] amp;
    logic        dc;
    logic        last;
  } sym_t;

  typedef struct {
    logic signed [11:0] c;
    int                 size;
    int                 amp;
  } tv_t;

  sym_t got0[$];
  sym_t got1[$];
  sym_t exp_q[$];
  int   chk_cnt = 0;
  int   err_cnt = 0;
  int   lowcnt = 0;
  int   errp = 0;
  int   stab_err = 0;
  logic tog_en = 1'b0;
  logic signed [11:0] blk [64];

  // Monitor: collect handshaken symbols, stall/ready statistics.
  sym_t prev_s;
  logic prev_stall = 1'b0;
  always @(negedge clk_i) begin
    sym_t c0, c1;
    c0 = {if0.sym_run_o, if0.sym_size_o, if0.sym_amp_o, if0.sym_dc_o, if0.sym_last_o};
    c1 = {if1.sym_run_o, if1.sym_size_o, if1.sym_amp_o, if1.sym_dc_o, if1.sym_last_o};
    if (rst_i == 1'b0) begin
      if (if0.sym_valid_o && if0.sym_ready_i) got0.push_back(c0);
      if (if1.sym_valid_o && if1.sym_ready_i) got1.push_back(c1);
      if (!if0.coef_ready_o) lowcnt++;
      if (if0.err_sop_o) errp++;
      if (prev_stall && (!if0.sym_valid_o || c0 != prev_s)) stab_err++;
      prev_stall = if0.sym_valid_o && !if0.sym_ready_i;
      prev_s     = c0;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // Downstream ready: always 1 unless toggling is enabled.
  initial begin
    if0.sym_ready_i = 1'b1;
    if1.sym_ready_i = 1'b1;
    forever begin
      @(posedge clk_i);
      #1;
      if (tog_en) if0.sym_ready_i = ~if0.sym_ready_i;
      else        if0.sym_ready_i = 1'b1;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic push_e(input int run, input int size, input int amp, input bit dc, input bit last);
    sym_t s;
    s.run  = 4'(run);
    s.size = 4'(size);
    s.amp  = 12'(amp);
    s.dc   = dc;
    s.last = last;
    exp_q.push_back(s);
  endtask

  task automatic check_syms(input string name, input int sel, input int base);
    int n;
    n = (sel == 0) ? got0.size() - base : got1.size() - base;
    check({name, " count"}, 32'(n), 32'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < n; k++) begin
      if (sel == 0) check($sformatf("%s sym%0d", name, k), 32'(got0[base+k]), 32'(exp_q[k]));
      else          check($sformatf("%s sym%0d", name, k), 32'(got1[base+k]), 32'(exp_q[k]));
    end
    exp_q.delete();
  endtask

  task automatic send(input int sel, input logic signed [11:0] c, input logic sop);
    int n;
    if (sel == 0) begin if0.coef_i = c; if0.coef_sop_i = sop; if0.coef_valid_i = 1'b1; end
    else          begin if1.coef_i = c; if1.coef_sop_i = sop; if1.coef_valid_i = 1'b1; end
    n = 0;
    @(negedge clk_i);
    while (!((sel == 0) ? if0.coef_ready_o : if1.coef_ready_o) && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 100) begin
      chk_cnt++;
      err_cnt++;
      $display("FAIL send timeout: waited %0d cycles, required ready", n);
    end
    @(posedge clk_i);
    #1;
    if (sel == 0) begin if0.coef_valid_i = 1'b0; if0.coef_sop_i = 1'b0; end
    else          begin if1.coef_valid_i = 1'b0; if1.coef_sop_i = 1'b0; end
  endtask

  task automatic send_blk(input int sel, input int len);
    for (int i = 0; i < len; i++) send(sel, blk[i], (i == 0));
  endtask

  task automatic clr_blk();
    for (int i = 0; i < 64; i++) blk[i] = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  function automatic int m_size(input int c);
    int m, s;
    m = (c < 0) ? -c : c;
    s = 0;
    while (m > 0) begin m = m >> 1; s++; end
    return s;
  endfunction

  function automatic int m_amp(input int c);
    return (c > 0) ? c : c + (1 << m_size(c)) - 1;
  endfunction

  // Free-running reference: symbols for blk[0..len-1].
  task automatic model(input int len, input bit eob);
    int z;
    push_e(0, m_size(int'(blk[0])), m_amp(int'(blk[0])), 1'b1, 1'b0);
    z = 0;
    for (int i = 1; i < len; i++) begin
      if (blk[i] == 0) z++;
      else begin
        while (z >= 16) begin push_e(15, 0, 0, 1'b0, 1'b0); z -= 16; end
        push_e(z, m_size(int'(blk[i])), m_amp(int'(blk[i])), 1'b0, (i == len - 1));
        z = 0;
      end
    end
    if (blk[len-1] == 0 && eob) push_e(0, 0, 0, 1'b0, 1'b1);
  endtask

  task automatic check_reset_outs(input string name);
    check({name, " valid"}, 32'(if0.sym_valid_o), 32'(0));
    check({name, " run"},   32'(if0.sym_run_o),   32'(0));
    check({name, " size"},  32'(if0.sym_size_o),  32'(0));
    check({name, " amp"},   32'(if0.sym_amp_o),   32'(0));
    check({name, " dc"},    32'(if0.sym_dc_o),    32'(0));
    check({name, " last"},  32'(if0.sym_last_o),  32'(0));
    check({name, " err"},   32'(if0.err_sop_o),   32'(0));
    check({name, " ready"}, 32'(if0.coef_ready_o), 32'(0));
  endtask

  initial begin
    tv_t tbl [14];
    int  base, l0, e0, s0, v, r;

    tbl[0]  = '{12'sd1,     1, 1};
    tbl[1]  = '{-12'sd1,    1, 0};
    tbl[2]  = '{12'sd2,     2, 2};
    tbl[3]  = '{-12'sd2,    2, 1};
    tbl[4]  = '{-12'sd5,    3, 2};
    tbl[5]  = '{12'sd7,     3, 7};
    tbl[6]  = '{12'sd25,    5, 25};
    tbl[7]  = '{-12'sd3,    2, 0};
    tbl[8]  = '{12'sd1023, 10, 1023};
    tbl[9]  = '{-12'sd1024, 11, 1023};
    tbl[10] = '{12'sd2047, 11, 2047};
    tbl[11] = '{-12'sd2047, 11, 0};
    tbl[12] = '{-12'sd256,  9, 255};
    tbl[13] = '{-12'sd100,  7, 27};

    if0.coef_i = '0; if0.coef_valid_i = 1'b0; if0.coef_sop_i = 1'b0;
    if1.coef_i = '0; if1.coef_valid_i = 1'b0; if1.coef_sop_i = 1'b0;
    rst_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    check_reset_outs("reset");
    rst_i = 1'b0;
    #1;
    check("ready after reset", 32'(if0.coef_ready_o), 32'(1));

    // DC=25, AC1=-3, zeros -> DC, {0,2,0}, EOB; one stall cycle
    clr_blk(); blk[0] = 12'sd25; blk[1] = -12'sd3;
    push_e(0, 5, 25, 1, 0); push_e(0, 2, 0, 0, 0); push_e(0, 0, 0, 0, 1);
    base = got0.size(); l0 = lowcnt; e0 = errp;
    send_blk(0, 64); idle(10);
    check_syms("eob block", 0, base);
    check("eob block ready low", 32'(lowcnt - l0), 32'(1));
    check("eob block err", 32'(errp - e0), 32'(0));

    // DC=0, AC36=7 -> two ZRLs then {3,3,7}, EOB
    clr_blk(); blk[36] = 12'sd7;
    push_e(0, 0, 0, 1, 0); push_e(15, 0, 0, 0, 0); push_e(15, 0, 0, 0, 0);
    push_e(3, 3, 7, 0, 0); push_e(0, 0, 0, 0, 1);
    base = got0.size(); l0 = lowcnt;
    send_blk(0, 64); idle(10);
    check_syms("zrl2 block", 0, base);
    check("zrl2 ready low", 32'(lowcnt - l0), 32'(3));

    // DC=1, AC63=-1024 after 62 zeros -> 3 ZRLs, {14,11,0x3FF,last}
    clr_blk(); blk[0] = 12'sd1; blk[63] = -12'sd1024;
    push_e(0, 1, 1, 1, 0);
    push_e(15, 0, 0, 0, 0); push_e(15, 0, 0, 0, 0); push_e(15, 0, 0, 0, 0);
    push_e(14, 11, 1023, 0, 1);
    base = got0.size(); l0 = lowcnt;
    send_blk(0, 64); idle(10);
    check_syms("zrl3 last", 0, base);
    check("zrl3 ready low", 32'(lowcnt - l0), 32'(3));

    // Size/amplitude table on consecutive AC positions
    clr_blk();
    for (int k = 0; k < 14; k++) blk[k+1] = tbl[k].c;
    base = got0.size();
    send_blk(0, 64); idle(10);
    check("table count", 32'(got0.size() - base), 32'(16));
    if (got0.size() - base >= 16) begin
      for (int k = 0; k < 14; k++) begin
        check($sformatf("table size %0d", k), 32'(got0[base+1+k].size), 32'(tbl[k].size));
        check($sformatf("table amp %0d", k),  32'(got0[base+1+k].amp),  32'(tbl[k].amp));
        check($sformatf("table run %0d", k),  32'(got0[base+1+k].run),  32'(0));
      end
      check("table eob", 32'(got0[base+15]), 32'({4'd0, 4'd0, 12'd0, 1'b0, 1'b1}));
    end

    // sop at idx 20 with 5 pending zeros
    base = got0.size(); e0 = errp;
    push_e(0, 3, 4, 1, 0);
    for (int k = 0; k < 14; k++) push_e(0, 2, 3, 0, 0);
    push_e(0, 3, 1, 1, 0); push_e(0, 0, 0, 0, 1);
    send(0, 12'sd4, 1'b1);
    for (int k = 1; k <= 14; k++) send(0, 12'sd3, 1'b0);
    for (int k = 15; k <= 19; k++) send(0, 12'sd0, 1'b0);
    send(0, -12'sd6, 1'b1);
    for (int k = 1; k <= 63; k++) send(0, 12'sd0, 1'b0);
    idle(10);
    check_syms("sop mid", 0, base);
    check("sop mid err pulses", 32'(errp - e0), 32'(1));

    // Random block with toggling sym_ready vs reference model
    clr_blk();
    blk[0] = 12'($urandom_range(0, 4094)) - 12'sd2047;
    for (int i = 1; i < 64; i++) begin
      r = $urandom_range(0, 9);
      if ((i >= 10 && i <= 30) || r < 6) blk[i] = '0;
      else begin
        v = $urandom_range(1, 2047);
        blk[i] = ($urandom_range(0, 1) == 1) ? 12'(-v) : 12'(v);
      end
    end
    model(64, 1'b1);
    base = got0.size(); s0 = stab_err;
    tog_en = 1'b1;
    send_blk(0, 64); idle(40);
    tog_en = 1'b0;
    idle(3);
    check_syms("toggle random", 0, base);
    check("toggle stable", 32'(stab_err - s0), 32'(0));

    // EOB_EN=0, BLK_LEN=16
    clr_blk(); blk[0] = 12'sd2;
    push_e(0, 2, 2, 1, 0);
    base = got1.size();
    send_blk(1, 16); idle(10);
    check_syms("noeob dc only", 1, base);
    clr_blk(); blk[0] = 12'sd3; blk[15] = -12'sd1;
    push_e(0, 2, 3, 1, 0); push_e(14, 1, 0, 0, 1);
    base = got1.size();
    send_blk(1, 16); idle(10);
    check_syms("noeob last ac", 1, base);

    // Reset asserted while ZRLs are pending
    clr_blk(); blk[41] = 12'sd5;
    for (int i = 0; i <= 41; i++) send(0, blk[i], (i == 0));
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    check_reset_outs("mid zrl reset");
    rst_i = 1'b0;
    #1;
    check("ready after mid reset", 32'(if0.coef_ready_o), 32'(1));
    base = got0.size();
    idle(8);
    check("after reset silent", 32'(got0.size() - base), 32'(0));
    clr_blk(); blk[0] = -12'sd1; blk[1] = 12'sd2;
    push_e(0, 1, 0, 1, 0); push_e(0, 2, 2, 0, 0); push_e(0, 0, 0, 0, 1);
    base = got0.size();
    send_blk(0, 64); idle(10);
    check_syms("post reset block", 0, base);

    $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
    $finish;
  end

endmodule
